// File: rtl/select_next_hop_pkg.sv
// Shared definitions for the next-hop selection stage: word type, neighbour
// table layout in data memory, result addresses and FSM state encoding.
package select_next_hop_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Neighbour table layout (byte addresses, 16-bit words, stride 2)
    localparam word_t ID_BASE       = 16'h0048;
    localparam word_t BATT_BASE     = 16'h0148;
    localparam word_t Q_BASE        = 16'h01C8;
    localparam word_t CNT_ADDR      = 16'h068A;

    // Result locations written at the end of every scan
    localparam word_t NEXT_HOP_ADDR = 16'h0710;
    localparam word_t OWN_COST_ADDR = 16'h0712;

    // Marker for "no usable neighbour"; also the saturated cost
    localparam word_t NO_HOP        = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_CNT,
        ST_CHECK,
        ST_LD_Q,
        ST_LD_BATT,
        ST_LD_ID,
        ST_WR_HOP,
        ST_WR_COST,
        ST_FIN,
        ST_WAIT
    } state_t;

    // Byte address of entry idx in a table starting at base
    function automatic word_t entry_addr(input word_t base, input word_t idx);
        return base + (idx << 1);
    endfunction

    // Unsigned add that clamps to all-ones instead of wrapping
    function automatic word_t sat_add(input word_t a, input word_t b);
        logic [WORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WORD_W] ? NO_HOP : sum[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/select_next_hop_hop_compare.sv
// Candidate-versus-current-best comparator. A candidate must have enough
// battery; it then wins if nothing was found yet, if its Q is strictly lower,
// or if Q ties and its battery is strictly higher. Full ties keep the earlier
// (lower-index) entry because the candidate does not win.
module hop_compare
    import select_next_hop_pkg::*;
(
    input  logic [WORD_W-1:0] q,
    input  logic [WORD_W-1:0] batt,
    input  logic [WORD_W-1:0] best_q,
    input  logic [WORD_W-1:0] best_batt,
    input  logic              found,
    input  logic [WORD_W-1:0] batt_min,
    output logic              take
);

    logic eligible;
    logic better_q;
    logic better_batt;

    // Pure combinational decision, unsigned 16-bit compares
    always_comb begin
        eligible    = (batt >= batt_min);
        better_q    = (q < best_q);
        better_batt = (q == best_q) && (batt > best_batt);
        take        = eligible && (!found || better_q || better_batt);
    end

endmodule

// File: rtl/select_next_hop.sv
// Scans the neighbour table in shared memory, picks the eligible neighbour
// with the lowest Q (battery breaks ties), writes the chosen ID and the
// node's own advertised cost back to memory and presents them on ports.
module select_next_hop
    import select_next_hop_pkg::*;
#(
    parameter int          MAX_NEIGHBORS = 64,
    parameter logic [15:0] HOP_COST      = 16'd1,
    parameter logic [15:0] BATT_MIN      = 16'd0
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [15:0] address,
    output logic        wr_en,
    output logic [15:0] data_out,
    output logic [15:0] next_hop,
    output logic [15:0] own_cost,
    output logic        no_route,
    output logic        done
);

    localparam word_t MAX_CNT = word_t'(MAX_NEIGHBORS);

    state_t state_reg, state_next;
    word_t  cnt_reg, cnt_next;
    word_t  n_reg, n_next;
    word_t  q_reg, q_next;
    word_t  batt_reg, batt_next;
    word_t  best_q_reg, best_q_next;
    word_t  best_batt_reg, best_batt_next;
    word_t  best_id_reg, best_id_next;
    logic   found_reg, found_next;
    word_t  address_reg, address_next;
    word_t  data_out_reg, data_out_next;
    logic   wr_en_reg, wr_en_next;
    logic   done_reg, done_next;
    word_t  next_hop_reg, next_hop_next;
    word_t  own_cost_reg, own_cost_next;
    logic   no_route_reg, no_route_next;

    logic   take;
    word_t  hop_value;
    word_t  cost_value;

    hop_compare u_hop_compare (
        .q         (q_reg),
        .batt      (batt_reg),
        .best_q    (best_q_reg),
        .best_batt (best_batt_reg),
        .found     (found_reg),
        .batt_min  (BATT_MIN),
        .take      (take)
    );

    // Result values as they will be written and published
    always_comb begin
        hop_value  = found_reg ? best_id_reg : NO_HOP;
        cost_value = found_reg ? sat_add(best_q_reg, HOP_COST) : NO_HOP;
    end

    // State and datapath registers; reset aborts any scan in progress
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            n_reg         <= '0;
            q_reg         <= '0;
            batt_reg      <= '0;
            best_q_reg    <= NO_HOP;
            best_batt_reg <= '0;
            best_id_reg   <= '0;
            found_reg     <= 1'b0;
            address_reg   <= '0;
            data_out_reg  <= '0;
            wr_en_reg     <= 1'b0;
            done_reg      <= 1'b0;
            next_hop_reg  <= NO_HOP;
            own_cost_reg  <= NO_HOP;
            no_route_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            n_reg         <= n_next;
            q_reg         <= q_next;
            batt_reg      <= batt_next;
            best_q_reg    <= best_q_next;
            best_batt_reg <= best_batt_next;
            best_id_reg   <= best_id_next;
            found_reg     <= found_next;
            address_reg   <= address_next;
            data_out_reg  <= data_out_next;
            wr_en_reg     <= wr_en_next;
            done_reg      <= done_next;
            next_hop_reg  <= next_hop_next;
            own_cost_reg  <= own_cost_next;
            no_route_reg  <= no_route_next;
        end
    end

    // Next-state logic: four cycles per neighbour, then two writes
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_LD_CNT;
            ST_LD_CNT:  state_next = ST_CHECK;
            ST_CHECK:   state_next = (n_reg == cnt_reg) ? ST_WR_HOP : ST_LD_Q;
            ST_LD_Q:    state_next = ST_LD_BATT;
            ST_LD_BATT: state_next = ST_LD_ID;
            ST_LD_ID:   state_next = ST_CHECK;
            ST_WR_HOP:  state_next = ST_WR_COST;
            ST_WR_COST: state_next = ST_FIN;
            ST_FIN:     state_next = ST_WAIT;
            ST_WAIT:    if (!start) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Datapath and output updates per state; memory reads are pipelined so
    // each state consumes the word addressed by the previous one
    always_comb begin
        cnt_next       = cnt_reg;
        n_next         = n_reg;
        q_next         = q_reg;
        batt_next      = batt_reg;
        best_q_next    = best_q_reg;
        best_batt_next = best_batt_reg;
        best_id_next   = best_id_reg;
        found_next     = found_reg;
        address_next   = address_reg;
        data_out_next  = data_out_reg;
        wr_en_next     = 1'b0;
        done_next      = done_reg;
        next_hop_next  = next_hop_reg;
        own_cost_next  = own_cost_reg;
        no_route_next  = no_route_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) address_next = CNT_ADDR;
            end
            ST_LD_CNT: begin
                cnt_next       = (data_in > MAX_CNT) ? MAX_CNT : data_in;
                n_next         = '0;
                best_q_next    = NO_HOP;
                best_batt_next = '0;
                found_next     = 1'b0;
            end
            ST_CHECK: begin
                if (n_reg != cnt_reg) address_next = entry_addr(Q_BASE, n_reg);
            end
            ST_LD_Q: begin
                q_next       = data_in;
                address_next = entry_addr(BATT_BASE, n_reg);
            end
            ST_LD_BATT: begin
                batt_next    = data_in;
                address_next = entry_addr(ID_BASE, n_reg);
            end
            ST_LD_ID: begin
                if (take) begin
                    best_id_next   = data_in;
                    best_q_next    = q_reg;
                    best_batt_next = batt_reg;
                    found_next     = 1'b1;
                end
                n_next = n_reg + 16'd1;
            end
            ST_WR_HOP: begin
                address_next  = NEXT_HOP_ADDR;
                data_out_next = hop_value;
                wr_en_next    = 1'b1;
            end
            ST_WR_COST: begin
                address_next  = OWN_COST_ADDR;
                data_out_next = cost_value;
                wr_en_next    = 1'b1;
            end
            ST_FIN: begin
                done_next     = 1'b1;
                next_hop_next = hop_value;
                own_cost_next = cost_value;
                no_route_next = !found_reg;
            end
            ST_WAIT: begin
                if (!start) done_next = 1'b0;
            end
            default: ;
        endcase
    end

    assign address  = address_reg;
    assign wr_en    = wr_en_reg;
    assign data_out = data_out_reg;
    assign next_hop = next_hop_reg;
    assign own_cost = own_cost_reg;
    assign no_route = no_route_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_select_next_hop.sv
// Directed bench for select_next_hop. Two instances share the clock and
// reset: unit 0 uses BATT_MIN=0, unit 1 uses BATT_MIN=5. Each has its own
// memory model with a combinational read of the registered address.
module tb_select_next_hop;

    logic        clock = 1'b0;
    logic        nreset;
    logic        start_s    [2];
    logic [15:0] data_in_s  [2];
    logic [15:0] address_s  [2];
    logic        wr_en_s    [2];
    logic [15:0] data_out_s [2];
    logic [15:0] next_hop_s [2];
    logic [15:0] own_cost_s [2];
    logic        no_route_s [2];
    logic        done_s     [2];

    logic [15:0] mem [2][1024];

    int cycle = 0;
    int wr_cnt  [2] = '{0, 0};
    int bad_wr  [2] = '{0, 0};
    int q_reads [2] = '{0, 0};
    int hop_wc  [2] = '{0, 0};
    int cost_wc [2] = '{0, 0};
    logic [15:0] hop_wv  [2];
    logic [15:0] cost_wv [2];

    int checks = 0;
    int fails  = 0;

    // Observations from the most recent scan
    logic [15:0] obs_hop, obs_cost, obs_hop_wv, obs_cost_wv;
    logic        obs_nr, obs_done;
    int          obs_hop_dc, obs_cost_dc, obs_wr, obs_bad, obs_qreads;

    always #5 clock = ~clock;

    assign data_in_s[0] = mem[0][address_s[0][10:1]];
    assign data_in_s[1] = mem[1][address_s[1][10:1]];

    select_next_hop #(.MAX_NEIGHBORS(64), .HOP_COST(16'd1), .BATT_MIN(16'd0)) dut (
        .clock(clock), .nreset(nreset), .start(start_s[0]), .data_in(data_in_s[0]),
        .address(address_s[0]), .wr_en(wr_en_s[0]), .data_out(data_out_s[0]),
        .next_hop(next_hop_s[0]), .own_cost(own_cost_s[0]),
        .no_route(no_route_s[0]), .done(done_s[0])
    );

    select_next_hop #(.MAX_NEIGHBORS(64), .HOP_COST(16'd1), .BATT_MIN(16'd5)) dut_bmin (
        .clock(clock), .nreset(nreset), .start(start_s[1]), .data_in(data_in_s[1]),
        .address(address_s[1]), .wr_en(wr_en_s[1]), .data_out(data_out_s[1]),
        .next_hop(next_hop_s[1]), .own_cost(own_cost_s[1]),
        .no_route(no_route_s[1]), .done(done_s[1])
    );

    // Memory write / read-activity monitor sampling pre-edge DUT values
    always @(posedge clock) begin
        cycle <= cycle + 1;
        for (int u = 0; u < 2; u++) begin
            if (wr_en_s[u]) begin
                wr_cnt[u] <= wr_cnt[u] + 1;
                if (address_s[u] == 16'h0710) begin
                    hop_wv[u] <= data_out_s[u];
                    hop_wc[u] <= cycle;
                end else if (address_s[u] == 16'h0712) begin
                    cost_wv[u] <= data_out_s[u];
                    cost_wc[u] <= cycle;
                end else begin
                    bad_wr[u] <= bad_wr[u] + 1;
                end
            end
            if (address_s[u] >= 16'h01C8 && address_s[u] < 16'h0290)
                q_reads[u] <= q_reads[u] + 1;
        end
    end

    task automatic clear_mem(input int u);
        for (int i = 0; i < 1024; i++) mem[u][i] = 16'h0000;
    endtask

    task automatic set_count(input int u, input logic [15:0] c);
        mem[u][16'h068A >> 1] = c;
    endtask

    task automatic set_nbr(input int u, input int idx, input logic [15:0] id,
                           input logic [15:0] q, input logic [15:0] batt);
        mem[u][(16'h0048 >> 1) + idx] = id;
        mem[u][(16'h01C8 >> 1) + idx] = q;
        mem[u][(16'h0148 >> 1) + idx] = batt;
    endtask

    // Start a scan on unit u, wait for done, optionally keep start high for
    // 'hold' more cycles, collect observations, then release start
    task automatic run_scan(input int u, input int hold, input string tag);
        int  e0, w0, q0, b0;
        bit  seen;
        w0 = wr_cnt[u]; q0 = q_reads[u]; b0 = bad_wr[u];
        @(posedge clock); #1;
        start_s[u] = 1'b1;
        e0 = cycle;
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (done_s[u]) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL %s done_timeout: done=%b required 1", tag, done_s[u]);
        end
        repeat (hold) @(negedge clock);
        obs_done    = done_s[u];
        obs_hop     = next_hop_s[u];
        obs_cost    = own_cost_s[u];
        obs_nr      = no_route_s[u];
        obs_hop_wv  = hop_wv[u];
        obs_cost_wv = cost_wv[u];
        obs_hop_dc  = hop_wc[u] - e0;
        obs_cost_dc = cost_wc[u] - e0;
        obs_wr      = wr_cnt[u] - w0;
        obs_bad     = bad_wr[u] - b0;
        obs_qreads  = q_reads[u] - q0;
        start_s[u] = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!done_s[u]) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL %s done_release: done=%b required 0", tag, done_s[u]);
        end
        $display("scan %s unit=%0d next_hop=%h own_cost=%h no_route=%b writes=%0d hop_wr@E%0d cost_wr@E%0d q_reads=%0d",
                 tag, u, obs_hop, obs_cost, obs_nr, obs_wr, obs_hop_dc, obs_cost_dc, obs_qreads);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (address_s[0] !== 16'h0000) begin fails++; $display("FAIL reset_address: got %h want 0000", address_s[0]); end
        checks++; if (data_out_s[0] !== 16'h0000) begin fails++; $display("FAIL reset_data_out: got %h want 0000", data_out_s[0]); end
        checks++; if (wr_en_s[0] !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en_s[0]); end
        checks++; if (done_s[0] !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_s[0]); end
        checks++; if (no_route_s[0] !== 1'b0) begin fails++; $display("FAIL reset_no_route: got %b want 0", no_route_s[0]); end
        checks++; if (next_hop_s[0] !== 16'hFFFF) begin fails++; $display("FAIL reset_next_hop: got %h want ffff", next_hop_s[0]); end
        checks++; if (own_cost_s[0] !== 16'hFFFF) begin fails++; $display("FAIL reset_own_cost: got %h want ffff", own_cost_s[0]); end
        $display("reset applied: address=%h wr_en=%b next_hop=%h own_cost=%h", address_s[0], wr_en_s[0], next_hop_s[0], own_cost_s[0]);
        nreset = 1'b1;
    endtask

    task automatic test_empty();
        clear_mem(0);
        set_count(0, 16'd0);
        run_scan(0, 0, "empty");
        checks++; if (obs_hop !== 16'hFFFF) begin fails++; $display("FAIL empty_next_hop: got %h want ffff", obs_hop); end
        checks++; if (obs_cost !== 16'hFFFF) begin fails++; $display("FAIL empty_own_cost: got %h want ffff", obs_cost); end
        checks++; if (obs_nr !== 1'b1) begin fails++; $display("FAIL empty_no_route: got %b want 1", obs_nr); end
        checks++; if (obs_hop_wv !== 16'hFFFF) begin fails++; $display("FAIL empty_hop_write: got %h want ffff", obs_hop_wv); end
        checks++; if (obs_cost_wv !== 16'hFFFF) begin fails++; $display("FAIL empty_cost_write: got %h want ffff", obs_cost_wv); end
        checks++; if (obs_hop_dc != 4) begin fails++; $display("FAIL empty_hop_edge: got E%0d want E4", obs_hop_dc); end
        checks++; if (obs_cost_dc != 5) begin fails++; $display("FAIL empty_cost_edge: got E%0d want E5", obs_cost_dc); end
        checks++; if (obs_wr != 2) begin fails++; $display("FAIL empty_write_count: got %0d want 2", obs_wr); end
    endtask

    task automatic load_basic();
        clear_mem(0);
        set_count(0, 16'd3);
        set_nbr(0, 0, 16'd5,  16'd40, 16'd10);
        set_nbr(0, 1, 16'd9,  16'd20, 16'd10);
        set_nbr(0, 2, 16'd12, 16'd30, 16'd10);
    endtask

    task automatic test_basic();
        load_basic();
        run_scan(0, 0, "basic");
        checks++; if (obs_hop !== 16'd9) begin fails++; $display("FAIL basic_next_hop: got %0d want 9", obs_hop); end
        checks++; if (obs_cost !== 16'd21) begin fails++; $display("FAIL basic_own_cost: got %0d want 21", obs_cost); end
        checks++; if (obs_nr !== 1'b0) begin fails++; $display("FAIL basic_no_route: got %b want 0", obs_nr); end
        checks++; if (obs_hop_wv !== 16'd9) begin fails++; $display("FAIL basic_hop_write: got %0d want 9", obs_hop_wv); end
        checks++; if (obs_cost_wv !== 16'd21) begin fails++; $display("FAIL basic_cost_write: got %0d want 21", obs_cost_wv); end
        checks++; if (obs_hop_dc != 16) begin fails++; $display("FAIL basic_hop_edge: got E%0d want E16", obs_hop_dc); end
        checks++; if (obs_cost_dc != 17) begin fails++; $display("FAIL basic_cost_edge: got E%0d want E17", obs_cost_dc); end
        checks++; if (obs_bad != 0) begin fails++; $display("FAIL basic_stray_writes: got %0d want 0", obs_bad); end
    endtask

    task automatic test_tie();
        clear_mem(0);
        set_count(0, 16'd2);
        set_nbr(0, 0, 16'd7, 16'd20, 16'd3);
        set_nbr(0, 1, 16'd8, 16'd20, 16'd9);
        run_scan(0, 0, "tie_batt");
        checks++; if (obs_hop !== 16'd8) begin fails++; $display("FAIL tie_batt_next_hop: got %0d want 8", obs_hop); end
        set_nbr(0, 0, 16'd7, 16'd20, 16'd9);
        run_scan(0, 0, "tie_full");
        checks++; if (obs_hop !== 16'd7) begin fails++; $display("FAIL tie_full_next_hop: got %0d want 7", obs_hop); end
        checks++; if (obs_cost !== 16'd21) begin fails++; $display("FAIL tie_full_own_cost: got %0d want 21", obs_cost); end
    endtask

    task automatic test_batt_min();
        clear_mem(1);
        set_count(1, 16'd2);
        set_nbr(1, 0, 16'd1, 16'd10, 16'd4);
        set_nbr(1, 1, 16'd2, 16'd50, 16'd6);
        run_scan(1, 0, "batt_min");
        checks++; if (obs_hop !== 16'd2) begin fails++; $display("FAIL batt_min_next_hop: got %0d want 2", obs_hop); end
        checks++; if (obs_cost !== 16'd51) begin fails++; $display("FAIL batt_min_own_cost: got %0d want 51", obs_cost); end
        checks++; if (obs_nr !== 1'b0) begin fails++; $display("FAIL batt_min_no_route: got %b want 0", obs_nr); end
        set_nbr(1, 1, 16'd2, 16'd50, 16'd4);
        run_scan(1, 0, "batt_none");
        checks++; if (obs_nr !== 1'b1) begin fails++; $display("FAIL batt_none_no_route: got %b want 1", obs_nr); end
        checks++; if (obs_hop !== 16'hFFFF) begin fails++; $display("FAIL batt_none_next_hop: got %h want ffff", obs_hop); end
        checks++; if (obs_cost_wv !== 16'hFFFF) begin fails++; $display("FAIL batt_none_cost_write: got %h want ffff", obs_cost_wv); end
    endtask

    task automatic test_saturate();
        clear_mem(0);
        set_count(0, 16'd1);
        set_nbr(0, 0, 16'd33, 16'hFFFF, 16'd0);
        run_scan(0, 0, "saturate");
        checks++; if (obs_cost !== 16'hFFFF) begin fails++; $display("FAIL saturate_own_cost: got %h want ffff", obs_cost); end
        checks++; if (obs_nr !== 1'b0) begin fails++; $display("FAIL saturate_no_route: got %b want 0", obs_nr); end
        checks++; if (obs_hop !== 16'd33) begin fails++; $display("FAIL saturate_next_hop: got %0d want 33", obs_hop); end
        checks++; if (obs_cost_wv !== 16'hFFFF) begin fails++; $display("FAIL saturate_cost_write: got %h want ffff", obs_cost_wv); end
    endtask

    task automatic test_hold_start();
        load_basic();
        run_scan(0, 8, "hold_start");
        checks++; if (obs_done !== 1'b1) begin fails++; $display("FAIL hold_done: got %b want 1", obs_done); end
        checks++; if (obs_wr != 2) begin fails++; $display("FAIL hold_write_count: got %0d want 2", obs_wr); end
    endtask

    task automatic test_reset_mid_scan();
        int w0;
        load_basic();
        w0 = wr_cnt[0];
        @(posedge clock); #1;
        start_s[0] = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        nreset = 1'b0;
        start_s[0] = 1'b0;
        @(posedge clock); #1;
        checks++; if (next_hop_s[0] !== 16'hFFFF) begin fails++; $display("FAIL midrst_next_hop: got %h want ffff", next_hop_s[0]); end
        checks++; if (own_cost_s[0] !== 16'hFFFF) begin fails++; $display("FAIL midrst_own_cost: got %h want ffff", own_cost_s[0]); end
        checks++; if (address_s[0] !== 16'h0000) begin fails++; $display("FAIL midrst_address: got %h want 0000", address_s[0]); end
        checks++; if (no_route_s[0] !== 1'b0) begin fails++; $display("FAIL midrst_no_route: got %b want 0", no_route_s[0]); end
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        checks++; if (wr_cnt[0] != w0) begin fails++; $display("FAIL midrst_writes: got %0d want 0", wr_cnt[0] - w0); end
        checks++; if (done_s[0] !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b want 0", done_s[0]); end
        $display("reset mid-scan: writes during abort=%0d", wr_cnt[0] - w0);
        run_scan(0, 0, "after_reset");
        checks++; if (obs_hop !== 16'd9) begin fails++; $display("FAIL after_reset_next_hop: got %0d want 9", obs_hop); end
        checks++; if (obs_hop_dc != 16) begin fails++; $display("FAIL after_reset_hop_edge: got E%0d want E16", obs_hop_dc); end
    endtask

    task automatic test_clamp();
        clear_mem(0);
        set_count(0, 16'd100);
        for (int i = 0; i < 100; i++) begin
            mem[0][(16'h0048 >> 1) + i] = 16'(i + 100);
            mem[0][(16'h01C8 >> 1) + i] = 16'(500 - i);
        end
        for (int i = 0; i < 64; i++) mem[0][(16'h0148 >> 1) + i] = 16'd1;
        run_scan(0, 0, "clamp");
        checks++; if (obs_qreads != 64) begin fails++; $display("FAIL clamp_entries_read: got %0d want 64", obs_qreads); end
        checks++; if (obs_hop !== 16'd163) begin fails++; $display("FAIL clamp_next_hop: got %0d want 163", obs_hop); end
        checks++; if (obs_cost !== 16'd438) begin fails++; $display("FAIL clamp_own_cost: got %0d want 438", obs_cost); end
        checks++; if (obs_hop_dc != 260) begin fails++; $display("FAIL clamp_hop_edge: got E%0d want E260", obs_hop_dc); end
        checks++; if (obs_cost_dc != 261) begin fails++; $display("FAIL clamp_cost_edge: got E%0d want E261", obs_cost_dc); end
    endtask

    initial begin
        clear_mem(0);
        clear_mem(1);
        test_reset();
        test_empty();
        test_basic();
        test_tie();
        test_batt_min();
        test_saturate();
        test_hold_start();
        test_reset_mid_scan();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
